hub75_fb_streamin: RTL
======================

HUB75_FB_STREAMIN -- requirements
Module: hub75_fb_streamin

Interface
REQ-001 SHALL have parameter N_BANKS, default 2, number of panel banks.
REQ-002 SHALL have parameter N_ROWS, default 32, rows per bank.
REQ-003 SHALL have parameter N_COLS, default 64, columns per row.
REQ-004 SHALL have parameter BITDEPTH, default 24, pixel width.
REQ-005 SHALL have parameters LOG_N_BANKS, LOG_N_ROWS and LOG_N_COLS, each defaulting to the $clog2 of its parent.
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port in_data, input, BITDEPTH bits, pixel.
REQ-009 SHALL have port in_sof, input, 1 bit, marks the first pixel of a frame.
REQ-010 SHALL have port in_valid, input, 1 bit; in_ready, output, 1 bit: the stream handshake.
REQ-011 SHALL have port wr_bank_addr, output, LOG_N_BANKS bits; wr_row_addr, output, LOG_N_ROWS bits.
REQ-012 SHALL have port wr_row_store, output, 1 bit; wr_row_rdy, input, 1 bit; wr_row_swap, output, 1 bit.
REQ-013 SHALL have port wr_data, output, BITDEPTH bits; wr_col_addr, output, LOG_N_COLS bits; wr_en, output, 1 bit.
REQ-014 SHALL have port frame_swap, output, 1 bit, one-cycle pulse.
REQ-015 SHALL have port resync, output, 1 bit, one-cycle pulse when a partial line is discarded.

Function
REQ-016 SHALL accept a beat in any cycle where in_valid and in_ready are both 1.
REQ-017 SHALL expect raster order: line index L = bank*N_ROWS + row, columns 0..N_COLS-1, L from 0 to N_BANKS*N_ROWS-1.
REQ-018 SHALL implement states FILL, WAIT_RDY, SWAP and FLUSH; in_ready SHALL be 1 only in FILL.
REQ-019 SHALL, for an accepted beat, register wr_en=1, wr_data=in_data and wr_col_addr=column counter, so the write appears exactly 1 cycle after acceptance; wr_en SHALL be 0 otherwise.
REQ-020 SHALL increment the column counter per beat; on accepting column N_COLS-1 it SHALL wrap the counter to 0 and enter WAIT_RDY.
REQ-021 In WAIT_RDY, SHALL wait for wr_row_rdy=1, then enter SWAP; the earliest wr_row_swap is 2 cycles after the last beat is accepted.
REQ-022 In SWAP, SHALL pulse wr_row_swap for 1 cycle; on the following cycle it SHALL pulse wr_row_store for 1 cycle with wr_bank_addr/wr_row_addr equal to the completed line.
REQ-023 In that same store cycle, SHALL return to FILL, overlapping fill of the next line with the framebuffer store.
REQ-024 SHALL hold wr_bank_addr/wr_row_addr stable from the store pulse until the next store pulse.
REQ-025 After storing the last line (L = N_BANKS*N_ROWS-1), SHALL wrap L to 0 and enter FLUSH instead of FILL.
REQ-026 In FLUSH, SHALL wait for wr_row_rdy=1, then pulse frame_swap for 1 cycle and enter FILL.
REQ-027 A beat with in_sof=1 in FILL SHALL become column 0 of line 0.
REQ-028 If that sof beat arrives with column counter != 0 or L != 0, SHALL discard the partial line (no swap, no store) and pulse resync 1 cycle later.
REQ-029 SHALL ignore in_sof on a beat that is already column 0 of line 0.
REQ-030 SHALL never assert wr_row_swap or wr_row_store while wr_row_rdy=0.

Reset
REQ-031 On rst_n=0, SHALL immediately enter FILL with column counter 0 and L 0.
REQ-032 On rst_n=0, SHALL force wr_en, wr_row_swap, wr_row_store, frame_swap and resync to 0, and wr_bank_addr, wr_row_addr, wr_col_addr and wr_data to 0.
REQ-033 SHALL drive in_ready=1 from the first cycle after reset release.
REQ-034 Reset mid-line SHALL discard the line without any swap or store.

Structure
REQ-035 State encodings and a shared HUB75 geometry-defaults header SHALL live in the shared include used by the hub75 blocks.
REQ-036 SHALL be a single module with no sub-modules; line and column counters SHALL be inline.

Verification
Use N_BANKS=2, N_ROWS=4, N_COLS=8, BITDEPTH=24, with wr_row_rdy held 1 unless stated.
REQ-037 Full frame of 64 beats, values 0..63, with in_valid always 1 -> 8 swap/store pairs, stores at (bank,row) (0,0)..(1,3), pixel k written at col k%8, and one frame_swap after the final store.
REQ-038 Hold wr_row_rdy=0 for 10 cycles after line 0 completes -> in_ready=0 and no swap during those cycles; swap occurs 1 cycle after rdy rises and store follows 1 cycle later.
REQ-039 Assert in_sof on the 5th beat of line 2 -> resync pulse, no store for line 2, and the sof pixel written at col 0 with the next store addressed (0,0).
REQ-040 Deassert rst_n on the 3rd beat of line 1 -> all outputs go to 0 asynchronously; after release, a fresh frame stores line (0,0) first.
REQ-041 Drive in_valid with a 1-on/1-off pattern -> wr_en only on accepted beats, with wr_col_addr contiguous 0..7.

Source files
------------

// File: rtl/hub75_fb_streamin_pkg.sv
// Shared HUB75 definitions: default panel geometry and stream-in FSM states.
package hub75_fb_streamin_pkg;

    // Default panel geometry shared by the hub75 blocks.
    localparam int HUB75_N_BANKS  = 2;
    localparam int HUB75_N_ROWS   = 32;
    localparam int HUB75_N_COLS   = 64;
    localparam int HUB75_BITDEPTH = 24;

    // Stream-in line assembler states.
    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,  // accepting pixels of the current line
        ST_WAIT_RDY = 2'd1,  // line complete, waiting for the line buffer
        ST_SWAP     = 2'd2,  // swap issued, store follows
        ST_FLUSH    = 2'd3   // last line stored, waiting to swap frames
    } state_e;

endpackage : hub75_fb_streamin_pkg

// File: rtl/hub75_fb_streamin.sv
// Pixel stream to HUB75 line-buffer writer: assembles raster-ordered beats
// into lines, swaps/stores each completed line and swaps frames at the end.
module hub75_fb_streamin
    import hub75_fb_streamin_pkg::*;
#(
    parameter int N_BANKS     = HUB75_N_BANKS,
    parameter int N_ROWS      = HUB75_N_ROWS,
    parameter int N_COLS      = HUB75_N_COLS,
    parameter int BITDEPTH    = HUB75_BITDEPTH,
    parameter int LOG_N_BANKS = $clog2(N_BANKS),
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITDEPTH-1:0]    in_data,
    input  logic                   in_sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LOG_N_BANKS-1:0] wr_bank_addr,
    output logic [LOG_N_ROWS-1:0]  wr_row_addr,
    output logic                   wr_row_store,
    input  logic                   wr_row_rdy,
    output logic                   wr_row_swap,
    output logic [BITDEPTH-1:0]    wr_data,
    output logic [LOG_N_COLS-1:0]  wr_col_addr,
    output logic                   wr_en,
    output logic                   frame_swap,
    output logic                   resync
);

    localparam logic [LOG_N_COLS-1:0]  COL_LAST  = LOG_N_COLS'(N_COLS - 1);
    localparam logic [LOG_N_ROWS-1:0]  ROW_LAST  = LOG_N_ROWS'(N_ROWS - 1);
    localparam logic [LOG_N_BANKS-1:0] BANK_LAST = LOG_N_BANKS'(N_BANKS - 1);

    state_e                 state_q, state_d;
    logic [LOG_N_COLS-1:0]  col_q, col_d;
    logic [LOG_N_ROWS-1:0]  row_q, row_d;
    logic [LOG_N_BANKS-1:0] bank_q, bank_d;

    logic                   wr_en_q, wr_en_d;
    logic [BITDEPTH-1:0]    wr_data_q, wr_data_d;
    logic [LOG_N_COLS-1:0]  wr_col_addr_q, wr_col_addr_d;
    logic                   wr_row_swap_q, wr_row_swap_d;
    logic                   wr_row_store_q, wr_row_store_d;
    logic [LOG_N_BANKS-1:0] wr_bank_addr_q, wr_bank_addr_d;
    logic [LOG_N_ROWS-1:0]  wr_row_addr_q, wr_row_addr_d;
    logic                   frame_swap_q, frame_swap_d;
    logic                   resync_q, resync_d;

    logic                   accept;
    logic                   mid_frame;
    logic [LOG_N_COLS-1:0]  col_eff;
    logic [LOG_N_ROWS-1:0]  row_eff;
    logic [LOG_N_BANKS-1:0] bank_eff;

    assign in_ready = (state_q == ST_FILL);
    assign accept   = in_valid && in_ready;

    // A start-of-frame beat restarts the raster at column 0 of line 0;
    // it is a resync only when the counters were not already there.
    assign mid_frame = (col_q != '0) || (row_q != '0) || (bank_q != '0);
    assign col_eff   = in_sof ? '0 : col_q;
    assign row_eff   = in_sof ? '0 : row_q;
    assign bank_eff  = in_sof ? '0 : bank_q;

    // Next-state and next-output logic for the line assembler.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        bank_d         = bank_q;
        wr_en_d        = 1'b0;
        wr_data_d      = wr_data_q;
        wr_col_addr_d  = wr_col_addr_q;
        wr_row_swap_d  = 1'b0;
        wr_row_store_d = 1'b0;
        wr_bank_addr_d = wr_bank_addr_q;
        wr_row_addr_d  = wr_row_addr_q;
        frame_swap_d   = 1'b0;
        resync_d       = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                if (accept) begin
                    wr_en_d       = 1'b1;
                    wr_data_d     = in_data;
                    wr_col_addr_d = col_eff;
                    resync_d      = in_sof && mid_frame;
                    row_d         = row_eff;
                    bank_d        = bank_eff;
                    if (col_eff == COL_LAST) begin
                        col_d   = '0;
                        state_d = ST_WAIT_RDY;
                    end else begin
                        col_d = col_eff + LOG_N_COLS'(1);
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (wr_row_rdy) begin
                    wr_row_swap_d = 1'b1;
                    state_d       = ST_SWAP;
                end
            end
            ST_SWAP: begin
                // Store the completed line and start filling the next one
                // in the same cycle; the last line of a frame goes to FLUSH.
                if (wr_row_rdy) begin
                    wr_row_store_d = 1'b1;
                    wr_bank_addr_d = bank_q;
                    wr_row_addr_d  = row_q;
                    state_d        = ST_FILL;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (bank_q == BANK_LAST) begin
                            bank_d  = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            bank_d = bank_q + LOG_N_BANKS'(1);
                        end
                    end else begin
                        row_d = row_q + LOG_N_ROWS'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (wr_row_rdy) begin
                    frame_swap_d = 1'b1;
                    state_d      = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State, counters and registered outputs; reset drops any partial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FILL;
            col_q          <= '0;
            row_q          <= '0;
            bank_q         <= '0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            wr_col_addr_q  <= '0;
            wr_row_swap_q  <= 1'b0;
            wr_row_store_q <= 1'b0;
            wr_bank_addr_q <= '0;
            wr_row_addr_q  <= '0;
            frame_swap_q   <= 1'b0;
            resync_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            bank_q         <= bank_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            wr_col_addr_q  <= wr_col_addr_d;
            wr_row_swap_q  <= wr_row_swap_d;
            wr_row_store_q <= wr_row_store_d;
            wr_bank_addr_q <= wr_bank_addr_d;
            wr_row_addr_q  <= wr_row_addr_d;
            frame_swap_q   <= frame_swap_d;
            resync_q       <= resync_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;
    assign wr_col_addr  = wr_col_addr_q;
    assign wr_row_swap  = wr_row_swap_q;
    assign wr_row_store = wr_row_store_q;
    assign wr_bank_addr = wr_bank_addr_q;
    assign wr_row_addr  = wr_row_addr_q;
    assign frame_swap   = frame_swap_q;
    assign resync       = resync_q;

endmodule : hub75_fb_streamin
